ahb_arbiter_mux: RTL and testbench
==================================

# ahb_arbiter_mux

Three-master AHB-Lite bus arbiter and master-side multiplexer. It owns bus grant with round-robin priority, burst protection and locked-transfer holding. It drives the shared address/control bus (`HADDRm`, `HTRANSm`, …) and the data-phase write bus (`HWDATAm`). These muxed buses feed the address decoder, the default slave and all other slaves. Master 0 is the default master and is granted when nobody requests.

## Interface
- No parameters; master count is fixed at 3 and master 0 is the default master.
- `HCLK` in 1: bus clock.
- `HRESETn` in 1: reset, asynchronous, active-low; clock is `HCLK`.
- `HREADY` in 1: bus-wide ready from the slave response mux; all state advances only when it is 1.
- `HBUSREQ` in 3: bus request; bit x belongs to master x.
- `HLOCK` in 3: locked-sequence request; bit x belongs to master x.
- `HADDRx` in 32 (x=0,1,2): master x address.
- `HTRANSx` in 2 (x=0,1,2): master x transfer type.
- `HWRITEx` in 1 (x=0,1,2): master x write flag.
- `HSIZEx` in 3 (x=0,1,2): master x transfer size.
- `HBURSTx` in 3 (x=0,1,2): master x burst type.
- `HPROTx` in 4 (x=0,1,2): master x protection.
- `HWDATAx` in 32 (x=0,1,2): master x write data.
- `HGRANT` out 3: one-hot grant, registered.
- `HMASTERm` out 4: address-phase owner index 0..2, upper 2 bits always 0.
- `HMASTLOCKm` out 1: address phase is locked.
- `HADDRm` out 32: muxed address.
- `HTRANSm` out 2: muxed transfer type.
- `HWRITEm` out 1: muxed write flag.
- `HSIZEm` out 3: muxed transfer size.
- `HBURSTm` out 3: muxed burst type.
- `HPROTm` out 4: muxed protection.
- `HWDATAm` out 32: muxed write data, selected by the data-phase owner.

## Operation
- **Registers.** The block holds five registers:
  - `g`: granted index.
  - `HMASTERm`: address-phase owner.
  - `dm`: data-phase owner.
  - `HMASTLOCKm`.
  - `bcnt`: 4-bit beats-remaining counter.
  - All five update only on `HCLK` edges with `HREADY`=1 and hold otherwise.
- **Handover on an `HREADY`=1 edge:**
  - `HMASTERm` <= `g`.
  - `HMASTLOCKm` <= `HLOCK[g]`.
  - `dm` <= `HMASTERm`.
- **Address/control mux** is combinational from `HMASTERm`. `HWDATAm` is combinational from `dm`.
- **Burst counter**, computed as `bcnt_next` from the current `HTRANSm`/`HBURSTm`:
  - NONSEQ loads length−1: 3 for WRAP4/INCR4, 7 for WRAP8/INCR8, 15 for WRAP16/INCR16, 0 for SINGLE/INCR.
  - SEQ decrements, saturating at 0.
  - BUSY holds.
  - IDLE clears to 0.
  - `bcnt` <= `bcnt_next`.
- **Hold condition:**
  - hold = (`HLOCK[g]` && `HBUSREQ[g]`) || (`bcnt_next` >= 2).
  - Under hold, `g` is unchanged.
  - Undefined-length INCR bursts are not protected; masters use `HLOCK` if they need to keep the bus.
- **Round-robin** (when not held, on an `HREADY`=1 edge):
  - Search order is g+1, g+2, g (mod 3).
  - `g` <= the first index with `HBUSREQ` set.
  - If no request is set, `g` <= 0.
- `HGRANT` = one-hot(`g`).
- Grant is never changed on an `HREADY`=0 edge, even if requests change.

## Timing
- **Reset values:**
  - `g`=0, `HGRANT`=3'b001, `HMASTERm`=0, `dm`=0, `HMASTLOCKm`=0, `bcnt`=0.
  - Muxed outputs therefore reflect master 0 immediately after reset.
- Reset asserted mid-burst or mid-lock returns to the reset state at once; there is no completion of the outstanding transfer.
- **Grant latency:**
  - A request at edge E (idle bus, `HREADY`=1) gives `HGRANT` at E.
  - `HMASTERm` follows at the next `HREADY`=1 edge.
  - `dm` follows at the `HREADY`=1 edge after that.
- **4-beat burst handover:**
  - Grant may move at the edge accepting beat 3 (`bcnt_next`=1).
  - The new owner takes the address bus at the edge accepting beat 4.
  - No address phase is lost.
- **Wait states:** with `HREADY`=0 the entire state freezes; `HWDATAm` stays on the old data-phase owner.
- **Simultaneous requests** from all masters with `g`=0 give grant order 1, 2, 0, 1, … with each transfer SINGLE.

## Test plan
- **Reset/default:**
  - Stimulus: assert reset, then release with `HBUSREQ`=000.
  - Required: `HGRANT`=001, `HMASTERm`=0, `HADDRm`=`HADDR0`, `HWDATAm`=`HWDATA0`.
- **Round-robin:**
  - Stimulus: `HBUSREQ`=111, all masters issuing NONSEQ SINGLE, `HREADY`=1.
  - Required: `HGRANT` sequence 010, 100, 001, 010 on consecutive edges; `HMASTERm` lags by one edge; `dm` lags by two.
- **Burst protection:**
  - Stimulus: master 1 owns the bus and issues INCR4 (NONSEQ, SEQ, SEQ, SEQ) with `HBUSREQ`=011.
  - Required: `HGRANT` stays 010 through beat 2; it changes to 001 at the beat-3 edge; `HMASTERm`=0 after the beat-4 edge.
- **Lock:**
  - Stimulus: master 2 with `HLOCK[2]`=1 and `HBUSREQ`=111 for 5 SINGLE transfers.
  - Required: `HGRANT`=100 throughout and `HMASTLOCKm`=1; after `HLOCK[2]` drops, grant moves to master 0.
- **Wait states:**
  - Stimulus: `HREADY`=0 for 3 cycles during a handover from master 0 to master 1.
  - Required: `HGRANT`, `HMASTERm` and `HWDATAm` are unchanged for those 3 cycles, then complete the handover on the first `HREADY`=1 edge.
- **Async reset mid-INCR8:**
  - Stimulus: pull `HRESETn` low at beat 5.
  - Required: all outputs return to reset values before the next clock edge, and `bcnt`=0.

Source files
------------

// File: rtl/ahb_arbiter_mux.sv
// Three-master AHB-Lite arbiter with round-robin grant, burst/lock holding,
// and the master-side address/control and write-data multiplexers.
module ahb_arbiter_mux (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [2:0]  HBUSREQ,
  input  logic [2:0]  HLOCK,
  input  logic [31:0] HADDR0,
  input  logic [1:0]  HTRANS0,
  input  logic        HWRITE0,
  input  logic [2:0]  HSIZE0,
  input  logic [2:0]  HBURST0,
  input  logic [3:0]  HPROT0,
  input  logic [31:0] HWDATA0,
  input  logic [31:0] HADDR1,
  input  logic [1:0]  HTRANS1,
  input  logic        HWRITE1,
  input  logic [2:0]  HSIZE1,
  input  logic [2:0]  HBURST1,
  input  logic [3:0]  HPROT1,
  input  logic [31:0] HWDATA1,
  input  logic [31:0] HADDR2,
  input  logic [1:0]  HTRANS2,
  input  logic        HWRITE2,
  input  logic [2:0]  HSIZE2,
  input  logic [2:0]  HBURST2,
  input  logic [3:0]  HPROT2,
  input  logic [31:0] HWDATA2,
  output logic [2:0]  HGRANT,
  output logic [3:0]  HMASTERm,
  output logic        HMASTLOCKm,
  output logic [31:0] HADDRm,
  output logic [1:0]  HTRANSm,
  output logic        HWRITEm,
  output logic [2:0]  HSIZEm,
  output logic [2:0]  HBURSTm,
  output logic [3:0]  HPROTm,
  output logic [31:0] HWDATAm
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NM    = 3;

  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  idx_t             g_q;
  idx_t             own_q;
  idx_t             dm_q;
  logic             lock_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [NM-1:0]    grant_q;

  idx_t             g_nxt;
  idx_t             rr_idx;
  logic [CNT_W-1:0] bcnt_nxt;
  logic             hold;
  logic             lock_g;
  logic             req_g;

  function automatic logic bit_at(input logic [NM-1:0] v, input idx_t i);
    case (i)
      2'd0:    bit_at = v[0];
      2'd1:    bit_at = v[1];
      2'd2:    bit_at = v[2];
      default: bit_at = 1'b0;
    endcase
  endfunction

  // First requester in the order a, b, c; master 0 when nobody requests.
  function automatic idx_t pick(input logic [NM-1:0] req, input idx_t a, input idx_t b,
                                input idx_t c);
    if (bit_at(req, a))      pick = a;
    else if (bit_at(req, b)) pick = b;
    else if (bit_at(req, c)) pick = c;
    else                     pick = 2'd0;
  endfunction

  // Address/control mux follows the address-phase owner.
  always_comb begin
    HADDRm  = HADDR0;
    HTRANSm = HTRANS0;
    HWRITEm = HWRITE0;
    HSIZEm  = HSIZE0;
    HBURSTm = HBURST0;
    HPROTm  = HPROT0;
    case (own_q)
      2'd1: begin
        HADDRm  = HADDR1;
        HTRANSm = HTRANS1;
        HWRITEm = HWRITE1;
        HSIZEm  = HSIZE1;
        HBURSTm = HBURST1;
        HPROTm  = HPROT1;
      end
      2'd2: begin
        HADDRm  = HADDR2;
        HTRANSm = HTRANS2;
        HWRITEm = HWRITE2;
        HSIZEm  = HSIZE2;
        HBURSTm = HBURST2;
        HPROTm  = HPROT2;
      end
      default: ;
    endcase
  end

  // Write data follows the data-phase owner, one handover behind the address bus.
  always_comb begin
    HWDATAm = HWDATA0;
    case (dm_q)
      2'd1:    HWDATAm = HWDATA1;
      2'd2:    HWDATAm = HWDATA2;
      default: ;
    endcase
  end

  // Beats remaining after the transfer currently on the address bus.
  always_comb begin
    bcnt_nxt = '0;
    case (HTRANSm)
      TR_NONSEQ: begin
        case (HBURSTm)
          3'b010, 3'b011: bcnt_nxt = CNT_W'(3);
          3'b100, 3'b101: bcnt_nxt = CNT_W'(7);
          3'b110, 3'b111: bcnt_nxt = CNT_W'(15);
          default:        bcnt_nxt = '0;
        endcase
      end
      TR_SEQ:  bcnt_nxt = (bcnt_q == '0) ? '0 : bcnt_q - CNT_W'(1);
      TR_BUSY: bcnt_nxt = bcnt_q;
      TR_IDLE: bcnt_nxt = '0;
      default: bcnt_nxt = '0;
    endcase
  end

  // Grant selection: hold for a live lock or a burst with two or more beats left.
  always_comb begin
    lock_g = bit_at(HLOCK, g_q);
    req_g  = bit_at(HBUSREQ, g_q);
    hold   = (lock_g && req_g) || (bcnt_nxt >= CNT_W'(2));
    rr_idx = '0;
    case (g_q)
      2'd1:    rr_idx = pick(HBUSREQ, 2'd2, 2'd0, 2'd1);
      2'd2:    rr_idx = pick(HBUSREQ, 2'd0, 2'd1, 2'd2);
      default: rr_idx = pick(HBUSREQ, 2'd1, 2'd2, 2'd0);
    endcase
    g_nxt = hold ? g_q : rr_idx;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      g_q     <= '0;
      grant_q <= NM'(1);
      own_q   <= '0;
      dm_q    <= '0;
      lock_q  <= 1'b0;
      bcnt_q  <= '0;
    end else if (HREADY) begin
      g_q     <= g_nxt;
      grant_q <= NM'(1) << g_nxt;
      own_q   <= g_q;
      lock_q  <= lock_g;
      dm_q    <= own_q;
      bcnt_q  <= bcnt_nxt;
    end
  end

  assign HGRANT     = grant_q;
  assign HMASTERm   = {2'b00, own_q};
  assign HMASTLOCKm = lock_q;

endmodule

// File: tb/tb_ahb_arbiter_mux.sv
// Scoreboard bench for ahb_arbiter_mux: a transaction-level model predicts
// grant/ownership per clock, a negedge monitor checks the DUT against it.
module tb_ahb_arbiter_mux;

  logic        HCLK;
  logic        HRESETn;
  logic        HREADY;
  logic [2:0]  hbusreq;
  logic [2:0]  hlock;
  logic [31:0] addr  [3];
  logic [1:0]  trans [3];
  logic        write [3];
  logic [2:0]  size  [3];
  logic [2:0]  burst [3];
  logic [3:0]  prot  [3];
  logic [31:0] wdata [3];

  logic [2:0]  HGRANT;
  logic [3:0]  HMASTERm;
  logic        HMASTLOCKm;
  logic [31:0] HADDRm;
  logic [1:0]  HTRANSm;
  logic        HWRITEm;
  logic [2:0]  HSIZEm;
  logic [2:0]  HBURSTm;
  logic [3:0]  HPROTm;
  logic [31:0] HWDATAm;

  ahb_arbiter_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
    .HBUSREQ(hbusreq), .HLOCK(hlock),
    .HADDR0(addr[0]), .HTRANS0(trans[0]), .HWRITE0(write[0]), .HSIZE0(size[0]),
    .HBURST0(burst[0]), .HPROT0(prot[0]), .HWDATA0(wdata[0]),
    .HADDR1(addr[1]), .HTRANS1(trans[1]), .HWRITE1(write[1]), .HSIZE1(size[1]),
    .HBURST1(burst[1]), .HPROT1(prot[1]), .HWDATA1(wdata[1]),
    .HADDR2(addr[2]), .HTRANS2(trans[2]), .HWRITE2(write[2]), .HSIZE2(size[2]),
    .HBURST2(burst[2]), .HPROT2(prot[2]), .HWDATA2(wdata[2]),
    .HGRANT(HGRANT), .HMASTERm(HMASTERm), .HMASTLOCKm(HMASTLOCKm),
    .HADDRm(HADDRm), .HTRANSm(HTRANSm), .HWRITEm(HWRITEm), .HSIZEm(HSIZEm),
    .HBURSTm(HBURSTm), .HPROTm(HPROTm), .HWDATAm(HWDATAm)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [2:0] grant;
    int         owner;
    int         dm;
    logic       lock;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: granted master, address owner, data owner, beats left.
  int   mg, mown, mdm, mbeats;
  logic mlock;

  function automatic int burst_len(input int b);
    if (b == 2 || b == 3) return 4;
    if (b == 4 || b == 5) return 8;
    if (b == 6 || b == 7) return 16;
    return 1;
  endfunction

  function automatic void model_reset();
    mg = 0; mown = 0; mdm = 0; mbeats = 0; mlock = 1'b0;
  endfunction

  function automatic void model_edge();
    int t, nb, ng, c;
    bit hold, found;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    if (!HREADY) return;
    t = int'(trans[mown]);
    case (t)
      2:       nb = burst_len(int'(burst[mown])) - 1;
      3:       nb = (mbeats > 0) ? mbeats - 1 : 0;
      1:       nb = mbeats;
      default: nb = 0;
    endcase
    hold = (hlock[mg] && hbusreq[mg]) || (nb >= 2);
    ng = mg;
    if (!hold) begin
      ng = 0;
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (mg + k) % 3;
        if (!found && hbusreq[c]) begin ng = c; found = 1; end
      end
    end
    mlock  = hlock[mg];
    mdm    = mown;
    mown   = mg;
    mg     = ng;
    mbeats = nb;
  endfunction

  function automatic void push_exp();
    exp_t ne;
    ne.grant = 3'(1 << mg);
    ne.owner = mown;
    ne.dm    = mdm;
    ne.lock  = mlock;
    exp_q.push_back(ne);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endfunction

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant", 64'(HGRANT), 64'(e.grant));
      chk("master", 64'(HMASTERm), 64'(e.owner));
      chk("mastlock", 64'(HMASTLOCKm), 64'(e.lock));
      chk("addrctrl", 64'({HADDRm, HTRANSm, HWRITEm, HSIZEm, HBURSTm, HPROTm}),
          64'({addr[e.owner], trans[e.owner], write[e.owner], size[e.owner],
               burst[e.owner], prot[e.owner]}));
      chk("wdata", 64'(HWDATAm), 64'(wdata[e.dm]));
    end
  end

  // One clock: model sees the inputs the DUT samples, optional async reset mid-cycle.
  task automatic tick(input bit rst_mid = 1'b0);
    @(posedge HCLK);
    model_edge();
    if (rst_mid) begin
      #2;
      HRESETn = 1'b0;
      model_reset();
    end
    push_exp();
    #1;
  endtask

  task automatic set_all(input logic [1:0] t, input logic [2:0] b);
    for (int i = 0; i < 3; i++) begin
      addr[i]  = $urandom;
      wdata[i] = $urandom;
      write[i] = 1'($urandom_range(0, 1));
      size[i]  = 3'($urandom_range(0, 2));
      prot[i]  = 4'($urandom);
      trans[i] = t;
      burst[i] = b;
    end
  endtask

  task automatic rand_all();
    set_all(2'b00, 3'b000);
    for (int i = 0; i < 3; i++) begin
      trans[i] = 2'($urandom);
      burst[i] = 3'($urandom);
    end
    hbusreq = 3'($urandom);
    hlock   = 3'($urandom) & 3'($urandom) & 3'($urandom);
    HREADY  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic own_master(input int m);
    for (int k = 0; k < 8 && !(mown == m && mg == m); k++) begin
      set_all(2'b00, 3'b000);
      tick();
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    hbusreq = 3'b000;
    hlock   = 3'b000;
    set_all(2'b00, 3'b000);
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    push_exp();
    HRESETn = 1'b1;

    // Default master with no requests
    repeat (3) begin set_all(2'b00, 3'b000); tick(); end

    // Round-robin with all masters requesting single transfers
    hbusreq = 3'b111;
    set_all(2'b10, 3'b000);
    repeat (7) begin tick(); set_all(2'b10, 3'b000); end

    // INCR4 burst from master 1 with master 0 also requesting
    hbusreq = 3'b010;
    own_master(1);
    hbusreq = 3'b011;
    set_all(2'b00, 3'b000);
    trans[1] = 2'b10; burst[1] = 3'b011;
    tick();
    for (int b = 0; b < 3; b++) begin
      set_all(2'b00, 3'b000);
      trans[1] = 2'b11; burst[1] = 3'b011;
      tick();
    end
    repeat (2) begin set_all(2'b00, 3'b000); tick(); end

    // Locked sequence from master 2
    hbusreq = 3'b111;
    hlock   = 3'b100;
    repeat (9) begin set_all(2'b10, 3'b000); tick(); end
    hlock = 3'b000;
    repeat (3) begin set_all(2'b10, 3'b000); tick(); end

    // Wait states during a handover from master 0 to master 1
    hbusreq = 3'b001;
    own_master(0);
    set_all(2'b00, 3'b000);
    tick();
    hbusreq = 3'b010;
    tick();
    HREADY = 1'b0;
    repeat (3) begin hbusreq = 3'($urandom); tick(); end
    HREADY  = 1'b1;
    hbusreq = 3'b010;
    repeat (3) tick();

    // Asynchronous reset in the middle of an INCR8 burst
    hbusreq = 3'b001;
    own_master(0);
    set_all(2'b00, 3'b000);
    trans[0] = 2'b10; burst[0] = 3'b101;
    hbusreq = 3'b011;
    tick();
    for (int b = 2; b <= 5; b++) begin
      set_all(2'b00, 3'b000);
      trans[0] = 2'b11; burst[0] = 3'b101;
      tick(b == 5);
    end
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (4) begin set_all(2'b10, 3'b000); tick(); end

    // Randomized traffic
    repeat (800) begin rand_all(); tick(); end

    HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
